instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 176 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - 8085-style opcode-fetch / memory-read bus-cycle sequencer
module instruction_fetch #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  req_type,
  input  logic [15:0] pc_addr,
  input  logic [7:0]  data_in,
  input  logic        ready,
  output logic [15:0] addr_out,
  output logic        ale,
  output logic        rd_n,
  output logic [1:0]  status,
  output logic        pc_inc,
  output logic        busy,
  output logic [7:0]  ir,
  output logic [7:0]  opnd_lo,
  output logic [7:0]  opnd_hi,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_TW   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  // Latched cycle type; 2'b11 is folded into operand-low when it is captured.
  localparam logic [1:0] CT_OPCODE  = 2'b00;
  localparam logic [1:0] CT_OPND_LO = 2'b01;
  localparam logic [1:0] CT_OPND_HI = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_OPCODE = 2'b11;
  localparam logic [1:0] ST_MEMRD  = 2'b10;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // State and datapath registers; reset clears everything immediately, so a
  // cycle interrupted in T3 never reaches its load edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      type_q  <= CT_OPCODE;
      addr_q  <= 16'h0000;
      wait_q  <= 8'h00;
      ir_q    <= 8'h00;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state sequencing, wait counting, address capture and byte steering.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    ir_d    = ir_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_T1;
          type_d  = (req_type == 2'b11) ? CT_OPND_LO : req_type;
          addr_d  = pc_addr;
        end
      end

      S_T1: begin
        state_d = S_T2;
      end

      S_T2: begin
        if (ready) begin
          state_d = S_T3;
        end else begin
          state_d = S_TW;
          wait_d  = 8'd1;
        end
      end

      S_TW: begin
        if (ready) begin
          state_d = S_T3;
        end else if (wait_q == MAX_WAIT_C) begin
          // Memory never answered: abandon the cycle without touching the PC
          // or any destination register.
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_T3: begin
        case (type_q)
          CT_OPCODE:  ir_d = data_in;
          CT_OPND_HI: hi_d = data_in;
          default:    lo_d = data_in;
        endcase
        if (type_q == CT_OPCODE) begin
          state_d = S_T4;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_T4: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobes and status decoded straight from the current T-state.
  always_comb begin
    ale    = (state_q == S_T1);
    rd_n   = !((state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3));
    pc_inc = (state_q == S_T3);
    busy   = (state_q != S_IDLE);
    if (state_q == S_IDLE) begin
      status = ST_IDLE;
    end else if (type_q == CT_OPCODE) begin
      status = ST_OPCODE;
    end else begin
      status = ST_MEMRD;
    end
  end

  assign addr_out = addr_q;
  assign ir       = ir_q;
  assign opnd_lo  = lo_q;
  assign opnd_hi  = hi_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard testbench for instruction_fetch
module tb_instruction_fetch;

  localparam int MAXW = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  req_type;
  logic [15:0] pc_addr;
  logic [7:0]  data_in;
  logic        ready;
  logic [15:0] addr_out;
  logic        ale;
  logic        rd_n;
  logic [1:0]  status;
  logic        pc_inc;
  logic        busy;
  logic [7:0]  ir;
  logic [7:0]  opnd_lo;
  logic [7:0]  opnd_hi;
  logic        done;
  logic        err;

  instruction_fetch #(.MAX_WAIT(MAXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_type (req_type),
    .pc_addr  (pc_addr),
    .data_in  (data_in),
    .ready    (ready),
    .addr_out (addr_out),
    .ale      (ale),
    .rd_n     (rd_n),
    .status   (status),
    .pc_inc   (pc_inc),
    .busy     (busy),
    .ir       (ir),
    .opnd_lo  (opnd_lo),
    .opnd_hi  (opnd_hi),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    int          done_cyc;
    int          pc_cyc;
    int          pcn;
    int          rdl;
    logic [1:0]  st;
    logic [15:0] ad;
    logic        er;
    logic [7:0]  e_ir;
    logic [7:0]  e_lo;
    logic [7:0]  e_hi;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_ir = 8'h00;
  logic [7:0] m_lo = 8'h00;
  logic [7:0] m_hi = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks each machine cycle from its ale and scores it on done.
  int          m_active = 0;
  int          m_cyc    = 0;
  int          m_pcn    = 0;
  int          m_pccyc  = 0;
  int          m_rdl    = 0;
  logic [1:0]  m_st     = 2'b00;
  logic [15:0] m_ad     = 16'h0000;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      m_active = 0;
    end else begin
      if (ale) begin
        m_active = 1;
        m_cyc    = 1;
        m_pcn    = 0;
        m_pccyc  = 0;
        m_rdl    = 0;
        m_st     = status;
        m_ad     = addr_out;
      end else if (m_active != 0) begin
        m_cyc++;
      end
      if (m_active != 0) begin
        if (pc_inc) begin
          m_pcn++;
          m_pccyc = m_cyc;
        end
        if (!rd_n) m_rdl++;
      end
      if (done) begin
        if (m_active == 0) begin
          chk("done_without_cycle", 32'(done), 32'(0));
        end else if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(m_cyc),   32'(e.done_cyc));
          chk("err",        32'(err),     32'(e.er));
          chk("pc_inc_cnt", 32'(m_pcn),   32'(e.pcn));
          chk("pc_inc_cyc", 32'(m_pccyc), 32'(e.pc_cyc));
          chk("rd_n_low",   32'(m_rdl),   32'(e.rdl));
          chk("status_t1",  32'(m_st),    32'(e.st));
          chk("addr_t1",    32'(m_ad),    32'(e.ad));
          chk("addr_hold",  32'(addr_out), 32'(e.ad));
          chk("ir",         32'(ir),      32'(e.e_ir));
          chk("opnd_lo",    32'(opnd_lo), 32'(e.e_lo));
          chk("opnd_hi",    32'(opnd_hi), 32'(e.e_hi));
          chk("done_rd_n",  32'(rd_n),    32'(1));
          chk("done_busy",  32'(busy),    32'(0));
          chk("done_stat",  32'(status),  32'(0));
        end
        m_active = 0;
      end
    end
  end

  // Issue one machine cycle starting in an IDLE cycle; returns inside the
  // cycle where done is expected, so the next call chains back-to-back.
  task automatic issue(input logic [1:0] t, input logic [15:0] a, input logic [7:0] d,
                       input int nwait, input int done_cyc, input bit tmo);
    exp_t e;
    if (!tmo) begin
      if (t == 2'b00)      m_ir = d;
      else if (t == 2'b10) m_hi = d;
      else                 m_lo = d;
    end
    e.done_cyc = done_cyc;
    e.pc_cyc   = tmo ? 0 : 3 + nwait;
    e.pcn      = tmo ? 0 : 1;
    e.rdl      = tmo ? 1 + MAXW : 2 + nwait;
    e.st       = (t == 2'b00) ? 2'b11 : 2'b10;
    e.ad       = a;
    e.er       = tmo;
    e.e_ir     = m_ir;
    e.e_lo     = m_lo;
    e.e_hi     = m_hi;
    exp_q.push_back(e);
    req      = 1'b1;
    req_type = t;
    pc_addr  = a;
    data_in  = d;
    ready    = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k < done_cyc; k++) begin
      ready = ((k >= 2) && (k <= 1 + nwait)) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    req      = 1'b0;
    req_type = 2'b00;
    pc_addr  = 16'h0000;
    data_in  = 8'h00;
    ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",   32'(addr_out), 32'(0));
    chk("rst_ir",     32'(ir),       32'(0));
    chk("rst_lo",     32'(opnd_lo),  32'(0));
    chk("rst_hi",     32'(opnd_hi),  32'(0));
    chk("rst_status", 32'(status),   32'(0));
    chk("rst_ale",    32'(ale),      32'(0));
    chk("rst_rd_n",   32'(rd_n),     32'(1));
    chk("rst_pc_inc", 32'(pc_inc),   32'(0));
    chk("rst_busy",   32'(busy),     32'(0));
    chk("rst_done",   32'(done),     32'(0));
    chk("rst_err",    32'(err),      32'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Opcode fetch, no waits
    issue(2'b00, 16'h1234, 8'h3E, 0, 5, 1'b0);
    // Operand pair back-to-back
    issue(2'b01, 16'h1235, 8'h34, 0, 4, 1'b0);
    issue(2'b10, 16'h1236, 8'h12, 0, 4, 1'b0);
    // Operand read with three wait states
    issue(2'b01, 16'h1237, 8'h56, 3, 7, 1'b0);
    // Ready arrives on the last permitted wait state
    issue(2'b10, 16'h3000, 8'h5A, MAXW, 4 + MAXW, 1'b0);
    // Timeout: ready never returns
    issue(2'b00, 16'h1238, 8'h99, 255, 3 + MAXW, 1'b0 | 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of T3
    req      = 1'b1;
    req_type = 2'b00;
    pc_addr  = 16'h2000;
    data_in  = 8'h77;
    ready    = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t3_pc_inc", 32'(pc_inc), 32'(1));
    chk("t3_rd_n",   32'(rd_n),   32'(0));
    rst = 1'b0;
    #1;
    chk("mid_rst_rd_n",   32'(rd_n),    32'(1));
    chk("mid_rst_pc_inc", 32'(pc_inc),  32'(0));
    chk("mid_rst_busy",   32'(busy),    32'(0));
    chk("mid_rst_ir",     32'(ir),      32'(0));
    chk("mid_rst_lo",     32'(opnd_lo), 32'(0));
    chk("mid_rst_addr",   32'(addr_out), 32'(0));
    m_ir = 8'h00;
    m_lo = 8'h00;
    m_hi = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Normal fetch after reset release
    issue(2'b00, 16'h2001, 8'hC3, 0, 5, 1'b0);
    // req_type 11 behaves as operand low
    issue(2'b11, 16'h2002, 8'hA5, 0, 4, 1'b0);
    // Opcode fetch with a single wait state
    issue(2'b00, 16'h0FFF, 8'h76, 1, 6, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
